// File: rtl/led_irq_ctrl.sv
// Interrupt coalescing stage for the LED counter: edge-counts led_int_i, raises a
// level irq once a programmable threshold is met, and holds off re-assertion after an ack.
module led_irq_ctrl (
  input  logic        clk100,
  input  logic        rst,
  input  logic        led_int_i,
  input  logic [31:0] int_cnt_i,
  input  logic        irq_en_i,
  input  logic [7:0]  coal_thr_i,
  input  logic [15:0] holdoff_i,
  input  logic        ack_i,
  output logic        irq_o,
  output logic [7:0]  pend_cnt_o,
  output logic [31:0] snap_cnt_o,
  output logic        ovf_o,
  output logic        int_clr_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, ASSERT, HOLDOFF} state_t;

  state_t      state;
  logic        led_q;
  logic [15:0] hold_tmr;

  logic        ev;
  logic        pend_full;
  logic [7:0]  pend_next;
  logic [7:0]  thr_eff;
  logic        thr_met;

  always_comb begin
    ev        = led_int_i & ~led_q;
    pend_full = (pend_cnt_o == 8'hff);
    pend_next = (ev && !pend_full) ? pend_cnt_o + 8'd1 : pend_cnt_o;
    thr_eff   = (coal_thr_i == 8'd0) ? 8'd1 : coal_thr_i;
    thr_met   = irq_en_i && (pend_next >= thr_eff);
  end

  // Events are counted in every state; the ack branch below overrides the count.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state      <= IDLE;
      led_q      <= 1'b0;
      pend_cnt_o <= 8'd0;
      snap_cnt_o <= 32'd0;
      ovf_o      <= 1'b0;
      irq_o      <= 1'b0;
      int_clr_o  <= 1'b0;
      hold_tmr   <= 16'd0;
    end else begin
      led_q      <= led_int_i;
      int_clr_o  <= 1'b0;
      pend_cnt_o <= pend_next;
      if (ev && pend_full)
        ovf_o <= 1'b1;

      case (state)
        IDLE, COLLECT: begin
          if (thr_met) begin
            state      <= ASSERT;
            irq_o      <= 1'b1;
            snap_cnt_o <= int_cnt_i;
          end else if (state == IDLE && pend_next != 8'd0) begin
            state <= COLLECT;
          end
        end
        ASSERT: begin
          if (!irq_en_i) begin
            state <= IDLE;
            irq_o <= 1'b0;
          end else if (ack_i) begin
            state      <= HOLDOFF;
            irq_o      <= 1'b0;
            pend_cnt_o <= {7'd0, ev};
            ovf_o      <= 1'b0;
            hold_tmr   <= holdoff_i;
            int_clr_o  <= 1'b1;
          end
        end
        HOLDOFF: begin
          // Threshold is deliberately not checked here; the exit state re-evaluates it.
          if (hold_tmr != 16'd0)
            hold_tmr <= hold_tmr - 16'd1;
          else
            state <= (pend_cnt_o != 8'd0) ? COLLECT : IDLE;
        end
        default: begin
          state <= IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/led_irq_ctrl.md
# led_irq_ctrl

Interrupt coalescing stage directly downstream of the LED counter partition. Converts the counter's `led_int_o` event output into a level interrupt for the PS, with a programmable coalescing threshold, post-acknowledge holdoff, a snapshot of the counter's `int_cnt_o`, and a one-cycle `int_clr_o` pulse that feeds back into the counter's `int_clr_i`. One clock domain (`clk100`).

## Interface
- No parameters; all widths are fixed.
- `clk100` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `led_int_i` in 1: from the counter's `led_int_o`. Only its rising edge counts as an event.
- `int_cnt_i` in 32: from the counter's `int_cnt_o`.
- `irq_en_i` in 1: interrupt enable. Quasi-static, from the register bank.
- `coal_thr_i` in 8: number of events required before `irq_o` asserts. 0 is treated as 1.
- `holdoff_i` in 16: number of holdoff cycles after an ack.
- `ack_i` in 1: single-cycle acknowledge pulse from software.
- `irq_o` out 1: level interrupt to the PS.
- `pend_cnt_o` out 8: pending event count, saturating.
- `snap_cnt_o` out 32: `int_cnt_i` captured when `irq_o` asserts.
- `ovf_o` out 1: sticky flag; an event arrived while `pend_cnt_o` was 255.
- `int_clr_o` out 1: one-cycle pulse to the counter's `int_clr_i`.

## Operation
- **Edge detect.**
  - `led_q` is a registered copy of `led_int_i`.
  - `ev = led_int_i & ~led_q`.
  - Events are counted in every state, whether or not `irq_en_i` is set.
- **Pending count.**
  - `pend_next = pend_cnt + ev`, saturating at 255.
  - If `ev` arrives while `pend_cnt == 255`, set `ovf_o` and leave the count at 255.
- **Threshold.** `thr_eff = (coal_thr_i == 0) ? 1 : coal_thr_i`.
- **FSM states:** IDLE, COLLECT, ASSERT, HOLDOFF.
  - IDLE and COLLECT, if `irq_en_i && pend_next >= thr_eff`: go to ASSERT and set `snap_cnt_o <= int_cnt_i` on the same edge.
  - IDLE, otherwise: go to COLLECT if `pend_next > 0`.
  - COLLECT, otherwise: stay. Threshold changes take effect on the next cycle's comparison.
  - ASSERT:
    - `irq_en_i == 0`: go to IDLE and keep `pend_cnt`. Re-enabling re-evaluates the threshold and recaptures the snapshot.
    - `ack_i`: go to HOLDOFF; `pend_cnt <= ev` (an event coincident with the ack is kept as 1); clear `ovf_o`; `hold_tmr <= holdoff_i`; `int_clr_o <= 1` for exactly one cycle.
    - Otherwise: stay.
  - HOLDOFF:
    - `hold_tmr != 0`: decrement; events keep accumulating; `ack_i` is ignored.
    - `hold_tmr == 0`: go to IDLE, or to COLLECT if `pend_cnt > 0`. The threshold is not evaluated in this state.
- **Outputs.**
  - `irq_o` is registered: high iff state is ASSERT.
  - `ack_i` outside ASSERT is ignored and does not clear `ovf_o`.
- **Snapshot.** `snap_cnt_o` holds its value until the next entry into ASSERT.
- **Reset** (`rst`, synchronous, highest priority):
  - state IDLE, `led_q = 0`, `pend_cnt_o = 0`, `snap_cnt_o = 0`, `ovf_o = 0`, `irq_o = 0`, `int_clr_o = 0`, `hold_tmr = 0`.
  - Reset mid-ASSERT drops `irq_o` on the next edge and does not pulse `int_clr_o`.
  - A `led_int_i` held high through reset release counts as an event on the first cycle after reset, because `led_q = 0`.

## Timing
- Let `led_int_i` first be high at edge N.
  - `pend_cnt_o` updates at N+1.
  - If the threshold is met, `irq_o` and `snap_cnt_o` update at N+1 (one cycle of latency).
- Let `ack_i` be high at edge A.
  - `irq_o` is low from A+1.
  - `int_clr_o` is high during the cycle A+1 to A+2 only.
  - HOLDOFF lasts `holdoff_i + 1` cycles: at least 1 cycle when `holdoff_i = 0`, at most 65536 cycles.
- Earliest re-assertion after an ack is A + `holdoff_i` + 3 edges, when the threshold is already met on the HOLDOFF exit.
- An event at the edge where `led_int_i` is sampled is never lost, including the ack cycle and the HOLDOFF exit cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset values:** assert `rst` for 2 cycles with `led_int_i = 1` -> all outputs 0. After release, `pend_cnt_o = 1` one cycle later; with `irq_en_i = 0`, `irq_o` stays 0.
- **Coalescing:** `irq_en_i = 1`, `coal_thr_i = 3`, `holdoff_i = 10`, `int_cnt_i = 0x1234`; drive 3 rising edges 5 cycles apart -> `irq_o` rises 1 cycle after the 3rd edge, `pend_cnt_o = 3`, `snap_cnt_o = 0x1234`.
- **Ack and holdoff:** from the previous scenario, pulse `ack_i` -> `irq_o` falls next cycle, `int_clr_o` is high for 1 cycle, `pend_cnt_o = 0`; 3 events during holdoff -> `irq_o` stays low until HOLDOFF ends (11 cycles), then asserts.
- **Coincident ack and event:** ack on the same cycle as an edge -> `pend_cnt_o = 1` after the ack. With `coal_thr_i = 0`, `irq_o` reasserts after the 1-cycle holdoff when `holdoff_i = 0`.
- **Saturation:** `irq_en_i = 0`, 260 edges -> `pend_cnt_o = 255`, `ovf_o = 1`; set `irq_en_i = 1` and ack -> `ovf_o = 0`, `pend_cnt_o = 0`.
- **Disable and reset mid-assert:** drop `irq_en_i` in ASSERT -> `irq_o` falls, `pend_cnt_o` retained. Separately, `rst` in ASSERT -> `irq_o = 0` next cycle and no `int_clr_o` pulse.
